// File: rtl/lsu_ctrl.sv
// Load/store unit between the datapath and a word-addressed memory with no byte enables.
// Sub-word stores are done as read-modify-write; loads are lane-selected and extended.
module lsu_ctrl #(
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_load,
  input  logic              req_store,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              resp_valid,
  output logic [31:0]       load_data,
  output logic              error,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LD_RD   = 3'd1;
  localparam logic [2:0] S_LD_DATA = 3'd2;
  localparam logic [2:0] S_ST_RD   = 3'd3;
  localparam logic [2:0] S_ST_WR   = 3'd4;
  localparam logic [2:0] S_ERR     = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [1:0]        off_q, off_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        f3_q, f3_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic              error_q, error_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [31:0]       load_data_q, load_data_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;

  logic              accept_c, err_c, legal_c, is_half_c, is_word_c;
  logic [4:0]        sh_c;
  logic [31:0]       lane_c, ext_c, mask_c, merge_c, wdata_c, ldata_c;
  logic              unused_addr;

  assign unused_addr = ^addr[31:ADDR_W+2];

  // Access legality, evaluated on the live request at accept time
  always_comb begin
    is_half_c = (funct3[1:0] == 2'b01);
    is_word_c = (funct3 == 3'b010);
    if (req_load) begin
      legal_c = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                (funct3 == 3'b100) || (funct3 == 3'b101);
    end else begin
      legal_c = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    end
    err_c = (req_load & req_store) | ~legal_c | (is_half_c & addr[0]) |
            (is_word_c & (addr[1:0] != 2'b00));
  end

  assign accept_c = req_valid & req_ready_q & (req_load | req_store);

  // Lane extraction / insertion for the latched byte offset
  always_comb begin
    sh_c   = {off_q, 3'b000};
    lane_c = mem_rdata >> sh_c;
    case (f3_q)
      3'b000:  ext_c = {{24{lane_c[7]}}, lane_c[7:0]};
      3'b001:  ext_c = {{16{lane_c[15]}}, lane_c[15:0]};
      3'b100:  ext_c = {24'd0, lane_c[7:0]};
      3'b101:  ext_c = {16'd0, lane_c[15:0]};
      default: ext_c = mem_rdata;
    endcase
    mask_c  = (f3_q == 3'b000) ? (32'h0000_00FF << sh_c) : (32'h0000_FFFF << sh_c);
    merge_c = (mem_rdata & ~mask_c) | ((wdata_q << sh_c) & mask_c);
  end

  // Data outputs follow memory during their response cycle, then hold
  always_comb begin
    ldata_c = (state_q == S_LD_DATA) ? ext_c : load_data_q;
    if (state_q == S_ST_WR) begin
      wdata_c = (f3_q == 3'b010) ? wdata_q : merge_c;
    end else begin
      wdata_c = mem_wdata_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    off_d        = off_q;
    idx_d        = idx_q;
    wdata_d      = wdata_q;
    f3_d         = f3_q;
    resp_valid_d = 1'b0;
    error_d      = error_q;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    load_data_d  = load_data_q;
    mem_wdata_d  = mem_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          off_d   = addr[1:0];
          idx_d   = addr[ADDR_W+1:2];
          wdata_d = wdata;
          f3_d    = funct3;
          if (err_c) begin
            state_d      = S_ERR;
            resp_valid_d = 1'b1;
            error_d      = 1'b1;
            load_data_d  = 32'd0;
          end else if (req_load) begin
            state_d    = S_LD_RD;
            mem_read_d = 1'b1;
          end else if (funct3 == 3'b010) begin
            state_d      = S_ST_WR;
            mem_write_d  = 1'b1;
            resp_valid_d = 1'b1;
            error_d      = 1'b0;
          end else begin
            state_d    = S_ST_RD;
            mem_read_d = 1'b1;
          end
        end
      end
      S_LD_RD: begin
        state_d      = S_LD_DATA;
        resp_valid_d = 1'b1;
        error_d      = 1'b0;
      end
      S_LD_DATA: begin
        state_d     = S_IDLE;
        load_data_d = ext_c;
      end
      S_ST_RD: begin
        state_d      = S_ST_WR;
        mem_write_d  = 1'b1;
        resp_valid_d = 1'b1;
        error_d      = 1'b0;
      end
      S_ST_WR: begin
        state_d     = S_IDLE;
        mem_wdata_d = wdata_c;
      end
      default: state_d = S_IDLE;
    endcase
    req_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      off_q        <= 2'd0;
      idx_q        <= '0;
      wdata_q      <= 32'd0;
      f3_q         <= 3'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      error_q      <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      load_data_q  <= 32'd0;
      mem_wdata_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      off_q        <= off_d;
      idx_q        <= idx_d;
      wdata_q      <= wdata_d;
      f3_q         <= f3_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      error_q      <= error_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      load_data_q  <= load_data_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  // Memory strobes are forced low while reset is held
  assign mem_read   = mem_read_q & rst_n;
  assign mem_write  = mem_write_q & rst_n;
  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign error      = error_q;
  assign mem_addr   = idx_q;
  assign load_data  = ldata_c;
  assign mem_wdata  = wdata_c;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: a byte-array memory reference model predicts every
// response, the memory strobes cycle by cycle, and the stored words.
module tb_lsu_ctrl;
  localparam int unsigned ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid, req_ready, req_load, req_store;
  logic [2:0]        funct3;
  logic [31:0]       addr, wdata;
  logic              resp_valid, error;
  logic [31:0]       load_data;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read, mem_write;
  logic [31:0]       mem_wdata, mem_rdata;

  logic [31:0] mem [32];
  logic [7:0]  ref_b [128];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_load(req_load), .req_store(req_store), .funct3(funct3), .addr(addr),
    .wdata(wdata), .resp_valid(resp_valid), .load_data(load_data), .error(error),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Synchronous-read memory without byte enables
  always @(posedge clk) begin
    if (mem_read) mem_rdata <= mem[mem_addr];
    if (mem_write) mem[mem_addr] <= mem_wdata;
  end

  function automatic int acc_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic ref_err(input logic ld, input logic st, input logic [2:0] f3,
                                   input logic [31:0] a);
    logic legal;
    if (ld && st) return 1'b1;
    if (ld) legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    else    legal = (f3 inside {3'd0, 3'd1, 3'd2});
    if (!legal) return 1'b1;
    return (int'(a[6:0]) % acc_size(f3)) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v;
    int n;
    int base;
    v = 32'd0;
    n = acc_size(f3);
    base = int'(a[6:0]);
    for (int i = 0; i < n; i++) v = v | (32'(ref_b[(base + i) % 128]) << (8 * i));
    if (!f3[2] && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
    if (!f3[2] && n == 2 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  function automatic logic [31:0] ref_word(input int idx);
    return {ref_b[4*idx+3], ref_b[4*idx+2], ref_b[4*idx+1], ref_b[4*idx]};
  endfunction

  // One request from the cycle it is offered until the cycle after its response
  task automatic run_op(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, output logic [31:0] got);
    logic err, got_resp, exp_rd, exp_wr;
    int lat, idx, n;
    logic [31:0] exp_ld, exp_w;
    err = ref_err(ld, st, f3, a);
    lat = err ? 1 : (ld ? 2 : ((f3 == 3'b010) ? 1 : 2));
    idx = int'(a[6:2]);
    exp_ld = (ld && !err) ? ref_load(f3, a) : 32'd0;
    if (st && !err) begin
      n = acc_size(f3);
      for (int i = 0; i < n; i++) ref_b[(int'(a[6:0]) + i) % 128] = wd[8*i +: 8];
    end
    exp_w = ref_word(idx);
    got = 32'hx;
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_at_offer: req_ready=%b required 1", req_ready);
    end
    req_valid = 1'b1; req_load = ld; req_store = st; funct3 = f3; addr = a; wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
    req_load = 1'b0; wdata = $urandom; addr = $urandom; funct3 = 3'($urandom);
    got_resp = 1'b0;
    for (int c = 1; c <= 4 && !got_resp; c++) begin
      exp_rd = !err && c == 1 && (ld || f3 != 3'b010);
      exp_wr = !err && st && c == lat;
      vectors++;
      if (mem_read !== exp_rd || mem_write !== exp_wr) begin
        miscompares++;
        $display("FAIL strobes a=%h f3=%0d cyc %0d: rd/wr=%b%b required %b%b",
                 a, f3, c, mem_read, mem_write, exp_rd, exp_wr);
      end
      vectors++;
      if (resp_valid !== (c == lat)) begin
        miscompares++;
        $display("FAIL resp_timing a=%h f3=%0d cyc %0d: resp_valid=%b required %b",
                 a, f3, c, resp_valid, (c == lat));
      end
      if (exp_rd || exp_wr) begin
        vectors++;
        if (mem_addr !== 5'(idx)) begin
          miscompares++;
          $display("FAIL mem_addr a=%h: got %0d required %0d", a, mem_addr, idx);
        end
      end
      if (resp_valid === 1'b1) begin
        got_resp = 1'b1;
        got = load_data;
        vectors++;
        if (error !== err) begin
          miscompares++;
          $display("FAIL error_flag a=%h f3=%0d: got %b required %b", a, f3, error, err);
        end
        if (ld || err) begin
          vectors++;
          if (load_data !== exp_ld) begin
            miscompares++;
            $display("FAIL load_data a=%h f3=%0d: got %h required %h", a, f3, load_data, exp_ld);
          end
        end
        if (exp_wr) begin
          vectors++;
          if (mem_wdata !== exp_w) begin
            miscompares++;
            $display("FAIL mem_wdata a=%h f3=%0d: got %h required %h", a, f3, mem_wdata, exp_w);
          end
        end
      end
      if (!got_resp) @(negedge clk);
    end
    @(negedge clk);
    vectors++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || mem_write !== 1'b0 || mem_read !== 1'b0) begin
      miscompares++;
      $display("FAIL after_resp: resp=%b ready=%b rd=%b wr=%b required 0 1 0 0",
               resp_valid, req_ready, mem_read, mem_write);
    end
    if (ld || err) begin
      vectors++;
      if (load_data !== exp_ld) begin
        miscompares++;
        $display("FAIL load_hold a=%h: got %h required %h", a, load_data, exp_ld);
      end
    end
    vectors++;
    if (mem[idx] !== ref_word(idx)) begin
      miscompares++;
      $display("FAIL mem_word %0d: got %h required %h", idx, mem[idx], ref_word(idx));
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
    funct3 = 3'd0; addr = 32'd0; wdata = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_strobes: rd/wr=%b%b required 00", mem_read, mem_write);
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || load_data !== 32'd0 || error !== 1'b0 ||
        mem_wdata !== 32'd0 || mem_addr !== 5'd0 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: ready=%b resp=%b ld=%h err=%b wd=%h ma=%0d rd=%b wr=%b",
               req_ready, resp_valid, load_data, error, mem_wdata, mem_addr, mem_read, mem_write);
    end
  endtask

  task automatic test_word_round_trip();
    logic [31:0] g;
    run_op(1'b0, 1'b1, 3'b010, 32'h08, 32'hDEAD_BEEF, g);
    run_op(1'b1, 1'b0, 3'b010, 32'h08, 32'h0, g);
    vectors++;
    if (g !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL round_trip: got %h required deadbeef", g);
    end
  endtask

  task automatic test_load_ext();
    logic [31:0] g;
    logic [2:0]  f3s [5] = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] as  [5] = '{32'h0C, 32'h0E, 32'h0F, 32'h0E, 32'h0C};
    logic [31:0] exs [5] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01};
    run_op(1'b0, 1'b1, 3'b010, 32'h0C, 32'h80FF_7F01, g);
    for (int i = 0; i < 5; i++) begin
      run_op(1'b1, 1'b0, f3s[i], as[i], 32'h0, g);
      vectors++;
      if (g !== exs[i]) begin
        miscompares++;
        $display("FAIL load_ext %0d: got %h required %h", i, g, exs[i]);
      end
    end
  endtask

  task automatic test_rmw();
    logic [31:0] g;
    run_op(1'b0, 1'b1, 3'b010, 32'h10, 32'h1122_3344, g);
    run_op(1'b0, 1'b1, 3'b000, 32'h11, 32'h0000_00AB, g);
    vectors++;
    if (mem[4] !== 32'h1122_AB44) begin
      miscompares++;
      $display("FAIL rmw_sb: got %h required 1122ab44", mem[4]);
    end
    run_op(1'b0, 1'b1, 3'b001, 32'h12, 32'h0000_CAFE, g);
    vectors++;
    if (mem[4] !== 32'hCAFE_AB44) begin
      miscompares++;
      $display("FAIL rmw_sh: got %h required cafeab44", mem[4]);
    end
  endtask

  task automatic test_errors();
    logic [31:0] g;
    run_op(1'b1, 1'b0, 3'b010, 32'h06, 32'h0, g);
    run_op(1'b0, 1'b1, 3'b001, 32'h03, 32'h1234, g);
    run_op(1'b1, 1'b0, 3'b011, 32'h00, 32'h0, g);
    run_op(1'b1, 1'b1, 3'b000, 32'h04, 32'h99, g);
  endtask

  task automatic test_ignore();
    req_valid = 1'b1; req_load = 1'b0; req_store = 1'b0; funct3 = 3'b010; addr = 32'h08;
    repeat (2) begin
      @(negedge clk);
      vectors++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
        miscompares++;
        $display("FAIL ignore: ready=%b resp=%b rd=%b wr=%b required 1 0 0 0",
                 req_ready, resp_valid, mem_read, mem_write);
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset_mid_store();
    logic [31:0] g;
    run_op(1'b0, 1'b1, 3'b010, 32'h00, 32'h0, g);
    req_valid = 1'b1; req_store = 1'b1; funct3 = 3'b000; addr = 32'h00; wdata = 32'h55;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_store = 1'b0;
    vectors++;
    if (mem_read !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_store_read: mem_read=%b required 1", mem_read);
    end
    rst_n = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 1) rst_n = 1'b1;
      vectors++;
      if (mem_write !== 1'b0 || resp_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL mid_store_abort cyc %0d: wr=%b resp=%b required 0 0", c, mem_write, resp_valid);
      end
    end
    vectors++;
    if (req_ready !== 1'b1 || mem[0] !== 32'd0) begin
      miscompares++;
      $display("FAIL mid_store_after: ready=%b word0=%h required 1 00000000", req_ready, mem[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] g;
    run_op(1'b0, 1'b1, 3'b001, 32'h1C, 32'h0000_BEEF, g);
    run_op(1'b1, 1'b0, 3'b010, 32'h1C, 32'h0, g);
    run_op(1'b1, 1'b0, 3'b101, 32'h1C, 32'h0, g);
    vectors++;
    if (g !== 32'h0000_BEEF) begin
      miscompares++;
      $display("FAIL back_to_back: got %h required 0000beef", g);
    end
  endtask

  task automatic test_random();
    logic [31:0] g, a;
    logic [2:0]  f3;
    logic        ld, st;
    int r;
    for (int i = 0; i < 120; i++) begin
      r = $urandom_range(0, 19);
      ld = (r < 9) || (r == 19);
      st = (r >= 9);
      f3 = 3'($urandom_range(0, 7));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (f3[1:0] == 2'b01) a[0] = 1'b0;
        else if (f3[1:0] != 2'b00) a[1:0] = 2'b00;
      end
      run_op(ld, st, f3, a, $urandom, g);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    for (int i = 0; i < 128; i++) ref_b[i] = 8'd0;
    mem_rdata = 32'd0;
    test_reset();
    test_word_round_trip();
    test_load_ext();
    test_rmw();
    test_errors();
    test_ignore();
    test_reset_mid_store();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store unit sitting between the ALU/register-file datapath and the word-addressed data memory.
- Accepts one load or store per request and converts the byte address to a word index.
- Performs read-modify-write for byte/halfword stores, because memory has no byte enables.
- Extracts and sign/zero-extends load data, and flags misaligned or illegal accesses without touching memory.

Parameters:
- ADDR_W, 5, width of memory word index (32-word memory).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle and able to accept a request.
- req_load  in  1  request is a load.
- req_store  in  1  request is a store.
- funct3  in  3  RISC-V width/sign code.
- addr  in  32  byte address (ALU result).
- wdata  in  32  store data (rs2).
- resp_valid  out  1  one-cycle completion pulse.
- load_data  out  32  extended load result; valid with resp_valid.
- error  out  1  misaligned/illegal access; valid with resp_valid.
- mem_addr  out  ADDR_W  word index, equal to addr[ADDR_W+1:2] of the latched request.
- mem_read  out  1  memory read enable.
- mem_write  out  1  memory write enable.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data; registered, valid the cycle after mem_read.

Behaviour:
- Reset: one clock and one active-low reset; reset is synchronous, active-low.
  - rst_n low at a rising edge sets state IDLE and clears all registers.
  - mem_read and mem_write are gated with rst_n, so they are 0 whenever rst_n=0.
  - After reset: req_ready=1; resp_valid=0, load_data=0, error=0, mem_read=0, mem_write=0, mem_wdata=0, mem_addr=0.
- Accept: a request is taken when req_valid & req_ready in IDLE.
  - addr, wdata, funct3 and the load/store type are latched.
  - req_ready=1 only in IDLE.
  - req_valid with neither req_load nor req_store is ignored and the unit stays in IDLE.
- Legal encodings: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
- Error detection, checked at accept:
  - Any other funct3, or req_load and req_store both high, is an error.
  - Halfword with addr[0]=1 is an error.
  - Word with addr[1:0]!=0 is an error.
  - Error path: state ERR; next cycle resp_valid=1, error=1, load_data=0; no memory access; then IDLE.
- States: IDLE, LD_RD, LD_DATA, ST_RD, ST_WR, ERR.
- Load timing (T0 = accept):
  - T1, LD_RD: mem_read=1.
  - T2, LD_DATA: select the lane from mem_rdata using the latched addr[1:0], little-endian (byte k = bits 8k+7:8k).
  - T2 also: extend (sign for LB/LH, zero for LBU/LHU), load_data valid, resp_valid=1, error=0.
  - T3: IDLE. Load latency is 2 cycles.
- SW: T1, ST_WR: mem_write=1, mem_wdata=wdata, resp_valid=1; T2: IDLE.
- SB/SH:
  - T1, ST_RD: mem_read=1.
  - T2, ST_WR: mem_wdata = mem_rdata with the addressed byte/half replaced by wdata[7:0]/wdata[15:0], all other bytes preserved.
  - T2 also: mem_write=1, resp_valid=1. T3: IDLE.
- Output hold rules:
  - mem_read and mem_write are never both 1.
  - mem_addr holds the latched index for the whole operation.
  - load_data and error hold their last response value until the next resp_valid.
  - resp_valid is exactly one cycle per accepted request.
- Bound: addr bits above ADDR_W+1 are ignored, so the address wraps modulo memory size.
- Reset mid-operation: the operation is abandoned, with no write and no resp_valid. A sub-word store reset in ST_RD never writes.
- Back-to-back: a new request can be accepted the cycle after resp_valid. There is no overlap.

Test Plan:
- Word round trip: SW addr=0x08 wdata=0xDEADBEEF, then LW addr=0x08 -> mem_write in cycle T1 at mem_addr=2; load resp_valid at T2 with load_data=0xDEADBEEF, error=0.
- Load extension: word 3 = 0x80FF7F01.
  - LB addr=0x0C -> 0x00000001; LB addr=0x0E -> 0xFFFFFFFF; LBU addr=0x0F -> 0x00000080.
  - LH addr=0x0E -> 0xFFFF80FF; LHU addr=0x0C -> 0x00007F01.
- Read-modify-write:
  - Word 4 = 0x11223344; SB addr=0x11 wdata=0xAB -> mem_read at T1, mem_write at T2, mem_wdata=0x1122AB44.
  - Then SH addr=0x12 wdata=0xCAFE -> word 4 becomes 0xCAFEAB44.
- Errors, each giving resp_valid one cycle after accept with error=1, mem_read=mem_write=0 throughout:
  - LW addr=0x06; SH addr=0x03; load funct3=011.
  - req_load=req_store=1.
- Reset mid-store: SB addr=0x00 wdata=0x55 with word 0 = 0; drop rst_n during ST_RD -> no mem_write, no resp_valid, IDLE with req_ready=1 after release, word 0 still 0.
- Back-to-back: LW immediately after a completed SH -> req_ready re-asserts the cycle after resp_valid; the second request is accepted and returns correct data after 2 cycles.
